// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// dmem_responder : word-addressed data-memory target with programmable waits.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 8,
  parameter int WAIT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemEnab,
  input  logic             MemWrite,
  input  logic [ASIZE-1:0] Addr,
  input  logic [DSIZE-1:0] WData,
  output logic [DSIZE-1:0] RData,
  output logic             Ready,
  output logic             Stall
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       cnt;
  logic [ASIZE-1:0] hold_addr;
  logic [DSIZE-1:0] hold_wdata;
  logic             hold_write;
  logic             accept;
  logic             complete;

  logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];

  // DONE doubles as an acceptance cycle so back-to-back requests lose no time.
  assign accept   = MemEnab && ((state == IDLE) || (state == DONE));
  assign complete = (state == WAITST) && (cnt == 3'd0);
  assign Stall    = MemEnab & ~Ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MemEnab) state_nxt = WAITST;
      WAITST:  if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = MemEnab ? WAITST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      Ready      <= 1'b0;
      RData      <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_write <= 1'b0;
    end else begin
      state <= state_nxt;
      Ready <= complete;
      if (accept) begin
        hold_addr  <= Addr;
        hold_wdata <= WData;
        hold_write <= MemWrite;
        cnt        <= WAIT_CNT;
      end else if ((state == WAITST) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      if (complete && !hold_write) RData <= mem[hold_addr];
    end
  end

  // Array is deliberately outside the reset domain; an aborted store never reaches complete.
  always_ff @(posedge clk) begin
    if (complete && hold_write) mem[hold_addr] <= hold_wdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// tb_dmem_responder : transaction-level checking of two responders (WAIT=2, WAIT=0).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b, mw;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, stall_a, stall_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sel    = 0;
  bit ready_now = 1'b0;

  logic [15:0] ref_mem [2][256];
  bit          valid   [2][256];
  logic [15:0] exp_rd  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder #(.DSIZE(16), .ASIZE(8), .WAIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .MemEnab(en_a), .MemWrite(mw), .Addr(addr),
    .WData(wdata), .RData(rdata_a), .Ready(ready_a), .Stall(stall_a)
  );

  dmem_responder #(.DSIZE(16), .ASIZE(8), .WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .MemEnab(en_b), .MemWrite(mw), .Addr(addr),
    .WData(wdata), .RData(rdata_b), .Ready(ready_b), .Stall(stall_b)
  );

  function automatic logic        rdy(); return (sel == 1) ? ready_b : ready_a; endfunction
  function automatic logic        stl(); return (sel == 1) ? stall_b : stall_a; endfunction
  function automatic logic [15:0] rdt(); return (sel == 1) ? rdata_b : rdata_a; endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_en(input logic v);
    if (sel == 1) en_b = v; else en_a = v;
  endtask

  // Called just after a falling edge; returns at the falling edge of the Ready cycle.
  task automatic access(input logic wr, input logic [7:0] a, input logic [15:0] d,
                        input bit scramble, output int done_cyc);
    int w;
    w = (sel == 1) ? 0 : 2;
    mw = wr; addr = a; wdata = d;
    set_en(1'b1);
    #1;
    chk("stall_req", 16'(stl()), ready_now ? 16'd0 : 16'd1);
    chk("ready_req", 16'(rdy()), 16'(ready_now));
    for (int k = 0; k <= w; k++) begin
      @(negedge clk); #1;
      chk("ready_wait", 16'(rdy()), 16'd0);
      chk("stall_wait", 16'(stl()), 16'd1);
      chk("rdata_hold", rdt(), exp_rd[sel]);
      if (scramble) begin
        addr = 8'($urandom); wdata = 16'($urandom); mw = 1'($urandom);
      end
    end
    if (wr) begin
      ref_mem[sel][a] = d;
      valid[sel][a]   = 1'b1;
    end else begin
      exp_rd[sel] = ref_mem[sel][a];
    end
    @(negedge clk); #1;
    chk("ready_done", 16'(rdy()), 16'd1);
    chk("stall_done", 16'(stl()), 16'd0);
    chk("rdata_done", rdt(), exp_rd[sel]);
    done_cyc  = cyc;
    ready_now = 1'b1;
  endtask

  task automatic idle(input int n, input bit force_wr);
    set_en(1'b0);
    for (int i = 0; i < n; i++) begin
      mw = force_wr ? 1'b1 : 1'($urandom);
      addr = 8'($urandom); wdata = 16'($urandom);
      @(negedge clk); #1;
      chk("ready_idle", 16'(rdy()), 16'd0);
      chk("stall_idle", 16'(stl()), 16'd0);
      chk("rdata_idle", rdt(), exp_rd[sel]);
      ready_now = 1'b0;
    end
  endtask

  initial begin
    int t1, t2, tmp;
    logic [7:0]  ra;
    logic [15:0] rd;
    logic        rw;

    en_a = 1'b0; en_b = 1'b0; mw = 1'b0; addr = '0; wdata = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) begin
      valid[s][i] = 1'b0; ref_mem[s][i] = '0;
    end
    rst_n = 1'b0;
    #2;
    chk("rst_ready_a", 16'(ready_a), 16'd0);
    chk("rst_rdata_a", rdata_a, 16'd0);
    chk("rst_ready_b", 16'(ready_b), 16'd0);
    chk("rst_rdata_b", rdata_b, 16'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Store then load with captured-request scrambling
    sel = 0;
    access(1'b1, 8'h3C, 16'hBEEF, 1'b1, t1);
    idle(1, 1'b0);
    access(1'b0, 8'h3C, 16'h0000, 1'b1, t1);
    chk("load_beef", rdata_a, 16'hBEEF);
    idle(2, 1'b0);

    // Back-to-back: preload then two loads with MemEnab held
    access(1'b1, 8'h00, 16'h1111, 1'b0, t1);
    access(1'b1, 8'h01, 16'h2222, 1'b0, t1);
    access(1'b0, 8'h00, 16'h0000, 1'b0, t1);
    chk("b2b_first", rdata_a, 16'h1111);
    access(1'b0, 8'h01, 16'h0000, 1'b0, t2);
    chk("b2b_second", rdata_a, 16'h2222);
    chk("b2b_gap", 16'(t2 - t1), 16'd4);

    // MemWrite without MemEnab must do nothing
    idle(5, 1'b1);
    access(1'b0, 8'h3C, 16'h0000, 1'b0, t1);
    chk("ignored_wr", rdata_a, 16'hBEEF);
    idle(1, 1'b0);

    // Asynchronous reset mid-cycle while a load is in flight
    mw = 1'b0; addr = 8'h01; en_a = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 16'(ready_a), 16'd0);
    chk("arst_rdata", rdata_a, 16'd0);
    chk("arst_stall", 16'(stall_a), 16'd1);
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk); en_a = 1'b0;
    #1 chk("arst_stall_lo", 16'(stall_a), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    ready_now = 1'b0;
    #1;
    access(1'b0, 8'h00, 16'h0000, 1'b0, t1);
    chk("post_rst_load", rdata_a, 16'h1111);
    idle(1, 1'b0);

    // Reset during the first wait state of a store aborts it
    access(1'b1, 8'h10, 16'h1234, 1'b0, t1);
    idle(1, 1'b0);
    mw = 1'b1; addr = 8'h10; wdata = 16'h5555; en_a = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 en_a = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk); rst_n = 1'b1;
    ready_now = 1'b0;
    #1;
    idle(2, 1'b0);
    access(1'b0, 8'h10, 16'h0000, 1'b0, t1);
    chk("abort_store", rdata_a, 16'h1234);
    idle(1, 1'b0);

    // WAIT=0 responder
    sel = 1;
    access(1'b1, 8'hFF, 16'h00A5, 1'b1, t1);
    access(1'b0, 8'hFF, 16'h0000, 1'b0, t2);
    chk("w0_load", rdata_b, 16'h00A5);
    chk("w0_gap", 16'(t2 - t1), 16'd2);
    idle(1, 1'b0);

    // Randomized transactions on both responders
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int n = 0; n < 30; n++) begin
        rw = 1'($urandom);
        ra = 8'($urandom);
        rd = 16'($urandom);
        if (!rw) begin
          for (int t = 0; t < 256 && !valid[s][ra]; t++) ra = 8'($urandom);
          if (!valid[s][ra]) rw = 1'b1;
        end
        access(rw, ra, rd, 1'($urandom), tmp);
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3), 1'b0);
      end
      idle(1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
